// File: rtl/pc_ifid_stage_if.sv
// pc_ifid_stage_if: fetch-loop and IF/ID bundle between the PC stage (slave) and its environment (master).
interface pc_ifid_stage_if #(parameter int PC_W = 10);
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc;
    logic [31:0]     inst_in;
    logic [31:0]     id_inst;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-1:0] id_pc_plus1;
    logic            id_valid;
    logic            halted;
    logic [31:0]     fetch_count;
    modport master (
        output stall, flush, redirect_valid, redirect_pc, inst_in,
        input  pc, id_inst, id_pc, id_pc_plus1, id_valid, halted, fetch_count
    );
    modport slave (
        input  stall, flush, redirect_valid, redirect_pc, inst_in,
        output pc, id_inst, id_pc, id_pc_plus1, id_valid, halted, fetch_count
    );
endinterface

// File: rtl/pc_ifid_stage.sv
// pc_ifid_stage: program counter plus IF/ID register with BOOT/RUN/HALT control.
// Optional capture counter enabled by defining PC_IFID_FETCH_COUNT_EN.
module pc_ifid_stage #(
    parameter int              PC_W      = 10,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     HALT_INST = 32'h0000000C
) (
    input logic           clk,
    input logic           rst_n,
    pc_ifid_stage_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt, id_pc_nxt, id_pc_plus1_nxt, pc_inc;
    logic [31:0]     id_inst_nxt;
    logic            id_valid_nxt, halted_nxt, capture;
    assign pc_inc = bus.pc + 1'b1;
    always_comb begin
        state_nxt       = state;
        pc_nxt          = bus.pc;
        id_inst_nxt     = bus.id_inst;
        id_pc_nxt       = bus.id_pc;
        id_pc_plus1_nxt = bus.id_pc_plus1;
        id_valid_nxt    = bus.id_valid;
        halted_nxt      = bus.halted;
        capture         = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    // wrong-path slot: data captured but never marked live
                    pc_nxt          = bus.redirect_pc;
                    id_inst_nxt     = bus.inst_in;
                    id_pc_nxt       = bus.pc;
                    id_pc_plus1_nxt = pc_inc;
                    id_valid_nxt    = 1'b0;
                end else if (bus.stall) begin
                    id_valid_nxt = bus.id_valid & ~bus.flush;
                end else begin
                    id_inst_nxt     = bus.inst_in;
                    id_pc_nxt       = bus.pc;
                    id_pc_plus1_nxt = pc_inc;
                    id_valid_nxt    = ~bus.flush;
                    capture         = ~bus.flush;
                    if (!bus.flush && bus.inst_in == HALT_INST) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            HALT: begin
                id_valid_nxt = 1'b0;
                if (bus.redirect_valid) begin
                    pc_nxt     = bus.redirect_pc;
                    halted_nxt = 1'b0;
                    state_nxt  = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            bus.pc          <= RESET_PC;
            bus.id_inst     <= '0;
            bus.id_pc       <= '0;
            bus.id_pc_plus1 <= '0;
            bus.id_valid    <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.pc          <= pc_nxt;
            bus.id_inst     <= id_inst_nxt;
            bus.id_pc       <= id_pc_nxt;
            bus.id_pc_plus1 <= id_pc_plus1_nxt;
            bus.id_valid    <= id_valid_nxt;
            bus.halted      <= halted_nxt;
        end
    end
`ifdef PC_IFID_FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.fetch_count <= '0;
        else if (capture) bus.fetch_count <= bus.fetch_count + 1'b1;
    end
`else
    logic unused_capture;
    assign unused_capture  = capture;
    assign bus.fetch_count = '0;
`endif
endmodule

// File: tb/tb_pc_ifid_stage.sv
// tb_pc_ifid_stage: directed vector table plus hand sequences for async reset, BOOT and fetch count.
module tb_pc_ifid_stage;
    localparam logic [31:0] A = 32'h20020005;
    localparam logic [31:0] C = 32'h0000000C;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    pc_ifid_stage_if #(.PC_W(10)) bus();
    pc_ifid_stage #(.PC_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        st, fl, rd;
        logic [9:0]  rpc;
        logic [31:0] inst;
        logic [9:0]  pc, ipc, ipp;
        logic        v, h;
        logic [31:0] iinst;
        int          fc;
    } vec_t;
    vec_t vecs[26];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] fc_exp(input int n);
`ifdef PC_IFID_FETCH_COUNT_EN
        return 32'(n);
`else
        return n < 0 ? 32'd1 : 32'd0;
`endif
    endfunction
    task automatic drive(input logic st, input logic fl, input logic rd, input logic [9:0] rpc, input logic [31:0] inst);
        bus.stall          = st;
        bus.flush          = fl;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.inst_in        = inst;
    endtask
    initial begin
        vecs[0]  = '{0,0,0,10'h000,A, 10'h000,10'h000,10'h000,0,0,32'h0,0};
        vecs[1]  = '{0,0,0,10'h000,A, 10'h001,10'h000,10'h001,1,0,A,1};
        vecs[2]  = '{0,0,0,10'h000,A, 10'h002,10'h001,10'h002,1,0,A,2};
        vecs[3]  = '{0,0,0,10'h000,A, 10'h003,10'h002,10'h003,1,0,A,3};
        vecs[4]  = '{0,0,0,10'h000,A, 10'h004,10'h003,10'h004,1,0,A,4};
        vecs[5]  = '{0,0,0,10'h000,A, 10'h005,10'h004,10'h005,1,0,A,5};
        vecs[6]  = '{1,0,0,10'h000,A, 10'h005,10'h004,10'h005,1,0,A,5};
        vecs[7]  = '{1,0,0,10'h000,A, 10'h005,10'h004,10'h005,1,0,A,5};
        vecs[8]  = '{1,1,0,10'h000,A, 10'h005,10'h004,10'h005,0,0,A,5};
        vecs[9]  = '{0,0,0,10'h000,A, 10'h006,10'h005,10'h006,1,0,A,6};
        vecs[10] = '{0,0,0,10'h000,A, 10'h007,10'h006,10'h007,1,0,A,7};
        vecs[11] = '{1,0,1,10'h3FE,A, 10'h3FE,10'h007,10'h008,0,0,A,7};
        vecs[12] = '{0,0,0,10'h000,A, 10'h3FF,10'h3FE,10'h3FF,1,0,A,8};
        vecs[13] = '{0,0,0,10'h000,A, 10'h000,10'h3FF,10'h000,1,0,A,9};
        vecs[14] = '{0,0,0,10'h000,A, 10'h001,10'h000,10'h001,1,0,A,10};
        vecs[15] = '{0,0,1,10'h009,A, 10'h009,10'h001,10'h002,0,0,A,10};
        vecs[16] = '{0,0,0,10'h000,C, 10'h009,10'h009,10'h00A,1,1,C,11};
        vecs[17] = '{1,1,0,10'h000,A, 10'h009,10'h009,10'h00A,0,1,C,11};
        vecs[18] = '{0,0,0,10'h000,A, 10'h009,10'h009,10'h00A,0,1,C,11};
        vecs[19] = '{0,0,1,10'h000,A, 10'h000,10'h009,10'h00A,0,0,C,11};
        vecs[20] = '{0,0,0,10'h000,A, 10'h001,10'h000,10'h001,1,0,A,12};
        vecs[21] = '{0,1,0,10'h000,A, 10'h002,10'h001,10'h002,0,0,A,12};
        vecs[22] = '{0,1,0,10'h000,C, 10'h003,10'h002,10'h003,0,0,C,12};
        vecs[23] = '{1,0,0,10'h000,C, 10'h003,10'h002,10'h003,0,0,C,12};
        vecs[24] = '{0,0,1,10'h00B,C, 10'h00B,10'h003,10'h004,0,0,C,12};
        vecs[25] = '{0,0,0,10'h000,A, 10'h00C,10'h00B,10'h00C,1,0,A,13};
        drive(0, 0, 0, '0, A);
        #2;
        chk("reset pc", 32'(bus.pc), 0);
        chk("reset id_inst", bus.id_inst, 0);
        chk("reset id_valid", 32'(bus.id_valid), 0);
        chk("reset halted", 32'(bus.halted), 0);
        chk("reset fetch_count", bus.fetch_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].rd, vecs[i].rpc, vecs[i].inst);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d pc", i), 32'(bus.pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d id_pc", i), 32'(bus.id_pc), 32'(vecs[i].ipc));
            chk($sformatf("v%0d id_pc_plus1", i), 32'(bus.id_pc_plus1), 32'(vecs[i].ipp));
            chk($sformatf("v%0d id_valid", i), 32'(bus.id_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d halted", i), 32'(bus.halted), 32'(vecs[i].h));
            chk($sformatf("v%0d id_inst", i), bus.id_inst, vecs[i].iinst);
            chk($sformatf("v%0d fetch_count", i), bus.fetch_count, fc_exp(vecs[i].fc));
        end
        // mid-cycle asynchronous reset while pc=12 and id_valid=1
        #2 rst_n = 1'b0;
        #1;
        chk("async pc", 32'(bus.pc), 0);
        chk("async id_pc", 32'(bus.id_pc), 0);
        chk("async id_pc_plus1", 32'(bus.id_pc_plus1), 0);
        chk("async id_inst", bus.id_inst, 0);
        chk("async id_valid", 32'(bus.id_valid), 0);
        chk("async halted", 32'(bus.halted), 0);
        chk("async fetch_count", bus.fetch_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, '0, A);
        @(posedge clk);
        @(negedge clk);
        chk("boot pc", 32'(bus.pc), 0);
        chk("boot id_valid", 32'(bus.id_valid), 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, i == 4, 0, '0, A);
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                chk("first id_valid", 32'(bus.id_valid), 1);
                chk("first id_pc", 32'(bus.id_pc), 0);
                chk("first id_pc_plus1", 32'(bus.id_pc_plus1), 1);
            end
            if (i == 4) chk("flushed slot id_valid", 32'(bus.id_valid), 0);
        end
        chk("count run pc", 32'(bus.pc), 9);
        chk("count run fetch_count", bus.fetch_count, fc_exp(8));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
